// File: rtl/triangle_setup.sv
// triangle_setup: groups screen-space fp32 vertices into triangles, converts
// x/y to s11.4, computes doubled signed area and a clamped pixel box, culls
// degenerate / back-facing / off-screen triangles, and queues the survivors
// in a small FIFO for the rasterizer (valid/ready).
module triangle_setup #(
  parameter int SCREEN_W   = 320,
  parameter int SCREEN_H   = 240,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [3:0][31:0] vertex_in,
  input  logic             restart_in,
  input  logic             cull_back_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [2:0][15:0] tri_x_out,
  output logic [2:0][15:0] tri_y_out,
  output logic [2:0][31:0] tri_z_out,
  output logic [33:0]      area_out,
  output logic [3:0][9:0]  bbox_out,
  output logic             overflow_out,
  output logic [15:0]      culled_count_out
);

  localparam int                AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]       DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic signed [15:0] XLIM = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] YLIM = 16'(SCREEN_H - 1);

  typedef struct packed {
    logic [2:0][15:0] x;
    logic [2:0][15:0] y;
    logic [2:0][31:0] z;
    logic [33:0]      area;
    logic [3:0][9:0]  bbox;
  } tri_t;

  // fp32 -> s11.4, truncating toward zero; denormals read as zero,
  // inf/NaN and out-of-range magnitudes saturate by sign.
  function automatic logic [15:0] f2fix(input logic [31:0] f);
    logic [7:0]  e;
    logic [23:0] mag;
    logic        sat;
    logic [15:0] r;
    e   = f[30:23];
    mag = '0;
    sat = 1'b0;
    if (e == 8'd0)        mag = '0;
    else if (e >= 8'd146) sat = 1'b1;
    else if (e >= 8'd123) mag = {1'b1, f[22:0]} >> (8'd146 - e);
    if (mag >= 24'd32767) sat = 1'b1;
    if (sat) r = f[31] ? 16'h8000 : 16'h7FFF;
    else     r = f[31] ? (16'd0 - {1'b0, mag[14:0]}) : {1'b0, mag[14:0]};
    return r;
  endfunction

  function automatic logic signed [15:0] min3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [15:0] max3(input logic signed [15:0] a, b, c);
    logic signed [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [9:0] clamp(input logic signed [15:0] v, input logic signed [15:0] lim);
    if (v[15])        return '0;
    else if (v > lim) return lim[9:0];
    else              return v[9:0];
  endfunction

  // ---------------- vertex grouping ----------------
  logic [1:0]       r_idx;
  logic [2:0][31:0] r_hx, r_hy, r_hz;
  logic [3:0]       r_vld_pipe;
  logic             r_s0_cb;
  logic [1:0]       w_slot;

  // A restart with a valid vertex makes that vertex slot 0.
  assign w_slot = restart_in ? 2'd0 : r_idx;

  // Collect vertices; the third one launches the triangle into the pipe.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx         <= '0;
      r_hx          <= '0;
      r_hy          <= '0;
      r_hz          <= '0;
      r_s0_cb       <= 1'b0;
      r_vld_pipe[0] <= 1'b0;
    end else begin
      r_vld_pipe[0] <= 1'b0;
      if (valid_in) begin
        case (w_slot)
          2'd0:    begin r_hx[0] <= vertex_in[0]; r_hy[0] <= vertex_in[1]; r_hz[0] <= vertex_in[2]; end
          2'd1:    begin r_hx[1] <= vertex_in[0]; r_hy[1] <= vertex_in[1]; r_hz[1] <= vertex_in[2]; end
          default: begin r_hx[2] <= vertex_in[0]; r_hy[2] <= vertex_in[1]; r_hz[2] <= vertex_in[2]; end
        endcase
        if (w_slot == 2'd2) begin
          r_idx         <= 2'd0;
          r_vld_pipe[0] <= 1'b1;
          r_s0_cb       <= cull_back_in;
        end else begin
          r_idx <= w_slot + 2'd1;
        end
      end else if (restart_in) begin
        r_idx <= 2'd0;
      end
    end
  end

  // ---------------- stage 1: fixed point ----------------
  logic [2:0][15:0] r_s1_x, r_s1_y;
  logic [2:0][31:0] r_s1_z;
  logic             r_s1_cb;

  // Convert the held vertices to s11.4.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld_pipe[1] <= 1'b0;
      r_s1_x <= '0; r_s1_y <= '0; r_s1_z <= '0; r_s1_cb <= 1'b0;
    end else begin
      r_vld_pipe[1] <= r_vld_pipe[0];
      if (r_vld_pipe[0]) begin
        for (int i = 0; i < 3; i++) begin
          r_s1_x[i] <= f2fix(r_hx[i]);
          r_s1_y[i] <= f2fix(r_hy[i]);
        end
        r_s1_z  <= r_hz;
        r_s1_cb <= r_s0_cb;
      end
    end
  end

  // ---------------- stage 2: differences, extents ----------------
  logic [2:0][15:0]   r_s2_x, r_s2_y;
  logic [2:0][31:0]   r_s2_z;
  logic               r_s2_cb;
  logic signed [16:0] r_s2_dx1, r_s2_dx2, r_s2_dy1, r_s2_dy2;
  logic signed [15:0] r_s2_xmin, r_s2_xmax, r_s2_ymin, r_s2_ymax;

  // Edge vectors from vertex 0 (17 bits, cannot wrap) and x/y min/max.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld_pipe[2] <= 1'b0;
      r_s2_x <= '0; r_s2_y <= '0; r_s2_z <= '0; r_s2_cb <= 1'b0;
      r_s2_dx1 <= '0; r_s2_dx2 <= '0; r_s2_dy1 <= '0; r_s2_dy2 <= '0;
      r_s2_xmin <= '0; r_s2_xmax <= '0; r_s2_ymin <= '0; r_s2_ymax <= '0;
    end else begin
      r_vld_pipe[2] <= r_vld_pipe[1];
      if (r_vld_pipe[1]) begin
        r_s2_x    <= r_s1_x;
        r_s2_y    <= r_s1_y;
        r_s2_z    <= r_s1_z;
        r_s2_cb   <= r_s1_cb;
        r_s2_dx1  <= {r_s1_x[1][15], r_s1_x[1]} - {r_s1_x[0][15], r_s1_x[0]};
        r_s2_dx2  <= {r_s1_x[2][15], r_s1_x[2]} - {r_s1_x[0][15], r_s1_x[0]};
        r_s2_dy1  <= {r_s1_y[1][15], r_s1_y[1]} - {r_s1_y[0][15], r_s1_y[0]};
        r_s2_dy2  <= {r_s1_y[2][15], r_s1_y[2]} - {r_s1_y[0][15], r_s1_y[0]};
        r_s2_xmin <= min3(r_s1_x[0], r_s1_x[1], r_s1_x[2]);
        r_s2_xmax <= max3(r_s1_x[0], r_s1_x[1], r_s1_x[2]);
        r_s2_ymin <= min3(r_s1_y[0], r_s1_y[1], r_s1_y[2]);
        r_s2_ymax <= max3(r_s1_y[0], r_s1_y[1], r_s1_y[2]);
      end
    end
  end

  // ---------------- stage 3: products, box ----------------
  logic signed [33:0] w_p1, w_p2;
  logic signed [15:0] w_xmin_i, w_xmax_i, w_ymin_i, w_ymax_i;

  assign w_p1 = $signed({{17{r_s2_dx1[16]}}, r_s2_dx1}) * $signed({{17{r_s2_dy2[16]}}, r_s2_dy2});
  assign w_p2 = $signed({{17{r_s2_dx2[16]}}, r_s2_dx2}) * $signed({{17{r_s2_dy1[16]}}, r_s2_dy1});
  // Floor to whole pixels.
  assign w_xmin_i = r_s2_xmin >>> 4;
  assign w_xmax_i = r_s2_xmax >>> 4;
  assign w_ymin_i = r_s2_ymin >>> 4;
  assign w_ymax_i = r_s2_ymax >>> 4;

  logic [2:0][15:0] r_s3_x, r_s3_y;
  logic [2:0][31:0] r_s3_z;
  logic             r_s3_cb, r_s3_off;
  logic [33:0]      r_s3_p1, r_s3_p2;
  logic [3:0][9:0]  r_s3_box;

  // Register the cross products and the screen-clamped box.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_vld_pipe[3] <= 1'b0;
      r_s3_x <= '0; r_s3_y <= '0; r_s3_z <= '0; r_s3_cb <= 1'b0; r_s3_off <= 1'b0;
      r_s3_p1 <= '0; r_s3_p2 <= '0; r_s3_box <= '0;
    end else begin
      r_vld_pipe[3] <= r_vld_pipe[2];
      if (r_vld_pipe[2]) begin
        r_s3_x   <= r_s2_x;
        r_s3_y   <= r_s2_y;
        r_s3_z   <= r_s2_z;
        r_s3_cb  <= r_s2_cb;
        r_s3_p1  <= w_p1;
        r_s3_p2  <= w_p2;
        r_s3_off <= w_xmax_i[15] | w_ymax_i[15] | (w_xmin_i > XLIM) | (w_ymin_i > YLIM);
        r_s3_box <= {clamp(w_ymax_i, YLIM), clamp(w_ymin_i, YLIM),
                     clamp(w_xmax_i, XLIM), clamp(w_xmin_i, XLIM)};
      end
    end
  end

  // ---------------- stage 4: cull / swap ----------------
  // The difference needs 35 bits, but a real triangle's area fits in 34.
  logic signed [34:0] w_area;
  logic signed [34:0] w_abs;
  logic               w_neg, w_cull, w_keep;
  tri_t               w_ent;

  assign w_area = {r_s3_p1[33], r_s3_p1} - {r_s3_p2[33], r_s3_p2};
  assign w_neg  = w_area[34];
  assign w_abs  = w_neg ? -w_area : w_area;
  assign w_cull = r_vld_pipe[3] & ((w_area == '0) | r_s3_off | (w_neg & r_s3_cb));
  assign w_keep = r_vld_pipe[3] & ~w_cull;

  // Clockwise survivors get vertices 1/2 swapped so area is always positive.
  always_comb begin
    w_ent      = '0;
    w_ent.x    = r_s3_x;
    w_ent.y    = r_s3_y;
    w_ent.z    = r_s3_z;
    w_ent.area = w_abs[33:0];
    w_ent.bbox = r_s3_box;
    if (w_neg) begin
      w_ent.x = {r_s3_x[1], r_s3_x[2], r_s3_x[0]};
      w_ent.y = {r_s3_y[1], r_s3_y[2], r_s3_y[0]};
      w_ent.z = {r_s3_z[1], r_s3_z[2], r_s3_z[0]};
    end
  end

  // ---------------- output FIFO ----------------
  tri_t          r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic [15:0]   r_culled;
  logic          w_pop, w_full, w_push;

  assign w_pop  = (r_cnt != '0) & ready_in;
  // Fullness is judged after a same-cycle pop.
  assign w_full = (r_cnt == DEPTH) & ~w_pop;
  assign w_push = w_keep & ~w_full;

  // FIFO storage, pointers, sticky overflow and the saturating cull count.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_culled <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wp] <= w_ent;
        r_wp        <= r_wp + AW'(1);
      end
      if (w_pop) r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_keep & w_full) r_ovf <= 1'b1;
      if (w_cull && r_culled != 16'hFFFF) r_culled <= r_culled + 16'd1;
    end
  end

  assign valid_out        = (r_cnt != '0);
  assign tri_x_out        = r_mem[r_rp].x;
  assign tri_y_out        = r_mem[r_rp].y;
  assign tri_z_out        = r_mem[r_rp].z;
  assign area_out         = r_mem[r_rp].area;
  assign bbox_out         = r_mem[r_rp].bbox;
  assign overflow_out     = r_ovf;
  assign culled_count_out = r_culled;

endmodule

// File: doc/triangle_setup.md
# triangle_setup

Downstream neighbour of the viewport transform stage. It consumes the stream of screen-space fp32 vertices, converts x/y to signed fixed point, and groups every three vertices into a triangle. For each triangle it computes the signed doubled area and a screen-clamped pixel bounding box, culls degenerate, back-facing and off-screen triangles, and queues survivors in a small FIFO. The rasterizer drains that FIFO through a valid/ready handshake.

## Interface
Parameters:
- SCREEN_W, 320, screen width in pixels
- SCREEN_H, 240, screen height in pixels
- FIFO_DEPTH, 4, triangle FIFO entries (power of two, ≥2)

Ports:
- clk_in  input  1  clock
- rst_in  input  1  reset; one clock; reset is asynchronous and active-high
- valid_in  input  1  vertex_in valid this cycle (no backpressure upstream)
- vertex_in  input  [3:0][31:0]  fp32 {w,z,y,x}; x,y in pixels
- restart_in  input  1  sync; resets vertex grouping to vertex 0
- cull_back_in  input  1  1 = cull negative-area triangles
- ready_in  input  1  rasterizer accepts triangle
- valid_out  output  1  triangle available
- tri_x_out, tri_y_out  output  [2:0][15:0]  signed s11.4 vertex coordinates
- tri_z_out  output  [2:0][31:0]  fp32 z, passed through unchanged
- area_out  output  34  signed doubled area, s.8 fraction; always >0 when valid_out is high
- bbox_out  output  [3:0][9:0]  {ymax,ymin,xmax,xmin}, integer pixels, clamped
- overflow_out  output  1  sticky; a triangle was dropped because the FIFO was full
- culled_count_out  output  16  saturating count of culled triangles

## Operation
- Float→fixed (x, y):
  - Result = trunc(v·16) toward zero, 16-bit two's complement.
  - Exponent 0 gives 0.
  - |v·16| ≥ 32767, exponent 255 (inf/NaN) saturates by sign to +32767 / −32768.
- Grouping: 2-bit index 0→1→2→0, advanced per valid_in.
  - restart_in forces the index to 0. If restart_in and valid_in are high in the same cycle, that vertex becomes vertex 0.
  - Partial triangles are discarded on restart or reset.
- Area:
  - A = (x1−x0)(y2−y0) − (x2−x0)(y1−y0).
  - Differences are 17 bits, products 34 bits.
  - A is computed at full precision, with no wrap possible.
- Cull rules:
  - A == 0 → cull.
  - A < 0 and cull_back_in → cull.
  - A < 0 and !cull_back_in → swap vertices 1 and 2 (x, y, z) and negate A.
  - cull_back_in is sampled with the third vertex.
- Bounding box:
  - xmin = floor(min x) and xmax = floor(max x); arithmetic shift right by 4.
  - Same rule for y.
  - If xmax < 0, ymax < 0, xmin > SCREEN_W−1 or ymin > SCREEN_H−1 → cull.
  - Otherwise clamp x to [0, SCREEN_W−1] and y to [0, SCREEN_H−1].
- culled_count_out increments once per culled triangle and saturates at 0xFFFF.
- FIFO:
  - Survivors are written in order.
  - If the FIFO is full at write time, the triangle is dropped and overflow_out is set. A drop does not count as a cull.
  - overflow_out clears only on reset.
- Output:
  - The head entry drives all tri/area/bbox outputs.
  - Pop happens on valid_out && ready_in.
  - Outputs stay stable while valid_out && !ready_in.

## Timing
- Pipeline from the clock edge k that samples the third vertex:
  - k+1: fixed-point vertices registered.
  - k+2: differences and min/max registered.
  - k+3: products and box registered.
  - k+4: cull/swap decision; FIFO write.
- The earliest valid_out is the cycle after edge k+4.
- Triangles arrive at most one per 3 cycles. The pipeline is fully pipelined, with no internal stall.
- A write and a pop in the same cycle on a full FIFO succeeds, with no drop. Full is evaluated after the pop.
- Write into an empty FIFO: valid_out rises the cycle after the write. There is no combinational bypass.
- Reset values:
  - valid_out = 0, overflow_out = 0, culled_count_out = 0.
  - FIFO empty, index = 0, pipeline valids = 0.
  - Data outputs = 0.
- Reset mid-pipeline discards every in-flight triangle.

## Test plan
- **Front-facing triangle.** Vertices (10,10), (100,10), (10,100) = x/y 0x41200000 / 0x42C80000, z = 0.5, ready_in = 1. Required: one triangle 5 cycles after the third valid; area_out = 2073600; bbox = {100,10,100,10}; tri_x = {160,1600,160}.
- **Back-facing triangle.** Swap the last two vertices of the front-facing case.
  - With cull_back_in = 1: no output; culled_count_out = 1.
  - With cull_back_in = 0: output vertex order (10,10), (100,10), (10,100); area_out = 2073600.
- **Degenerate and off-screen.** Send collinear (0,0), (5,5), (10,10), then (400,10), (500,10), (400,50). Required: both culled; culled_count_out = 2. A partially off-screen triangle (−20,−20), (50,−20), (−20,50) is kept with bbox {50,0,50,0}.
- **Backpressure and overflow.** Hold ready_in = 0 and send FIFO_DEPTH+1 valid triangles back to back. Required: the first FIFO_DEPTH are held in order; the last is dropped; overflow_out = 1. Then raise ready_in: exactly FIFO_DEPTH triangles pop in order.
- **Restart and reset.**
  - Send 2 vertices, then restart_in together with a valid vertex, plus 2 more. Required: the triangle is formed from the last 3 vertices.
  - Assert rst_in asynchronously mid-pipeline. Required: valid_out drops immediately, no stale triangle appears afterwards, and all counters are 0.
- **Saturation.** Send x = 1e6 and x = −inf. Required: tri_x = 32767 and −32768; bbox clamped to [0,319].
